leaf_stream_bridge: RTL and testbench
=====================================

LEAF_STREAM_BRIDGE -- requirements
Module: leaf_stream_bridge

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32, user data width.
REQ-002 SHALL have parameter NUM_LEAF_BITS, default 5, leaf-address field width.
REQ-003 SHALL have parameter NUM_PORT_BITS, default 4, port field width.
REQ-004 SHALL have parameter NUM_ADDR_BITS, default 7, sequence field width.
REQ-005 SHALL have parameter PACKET_BITS, default 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS (49).
REQ-006 SHALL have parameters NUM_IN_PORTS and NUM_OUT_PORTS, default 2 each, range 1..2^NUM_PORT_BITS.
REQ-007 SHALL have parameter FIFO_DEPTH, default 16, per-output-port buffer depth, power of 2.
REQ-008 SHALL have parameters DEST_LEAF_TABLE and DEST_PORT_TABLE, packed vectors, destination leaf/port per input port i.
REQ-009 clk  input  1  single clock; reset is synchronous and active-high.
REQ-010 reset  input  1  synchronous, active-high.
REQ-011 din_leaf_bft2interface  input  PACKET_BITS  inbound packet: [MSB]=valid, then leaf, port, addr, payload (LSBs).
REQ-012 dout_leaf_interface2bft  output  PACKET_BITS  outbound packet, same format.
REQ-013 resend  input  1  retransmit last outbound packet.
REQ-014 dout_leaf_interface2user  output  NUM_OUT_PORTS*PAYLOAD_BITS  per-port user data.
REQ-015 vld_interface2user / ack_user2interface  output / input  NUM_OUT_PORTS  per-port handshake.
REQ-016 din_leaf_user2interface  input  NUM_IN_PORTS*PAYLOAD_BITS  per-port user data.
REQ-017 vld_user2interface / ack_interface2user  input / output  NUM_IN_PORTS  per-port handshake.
REQ-018 drop_count  output  16  inbound drop counter (LEAF_DROP_CNT_EN only).

Function
REQ-019 Handshake: a word transfers in any cycle where vld and ack are both 1; vld, once asserted, SHALL hold with stable data until transfer.
REQ-020 Inbound packet with valid=1 and port p < NUM_OUT_PORTS SHALL be written to FIFO p; payload visible on that port at earliest one cycle later (show-ahead).
REQ-021 Inbound packet with port >= NUM_OUT_PORTS, or targeting a full FIFO, SHALL be dropped; the leaf field is ignored.
REQ-022 Simultaneous write and read on a full FIFO SHALL drop the write (full evaluated before read).
REQ-023 vld_interface2user[p] SHALL equal FIFO p non-empty; pointers wrap modulo FIFO_DEPTH.
REQ-024 Outbound: round-robin arbiter SHALL grant exactly one requesting input port per cycle, starting search at last grant+1, wrapping at NUM_IN_PORTS.
REQ-025 ack_interface2user SHALL be combinational: one-hot grant, all zero when resend=1 or reset=1.
REQ-026 Granted word at cycle t SHALL appear on dout_leaf_interface2bft at t+1 with valid=1, leaf=DEST_LEAF_TABLE[i], port=DEST_PORT_TABLE[i], addr=seq[i].
REQ-027 seq[i] SHALL increment by 1 per sent packet of port i, wrapping at 2^NUM_ADDR_BITS.
REQ-028 Cycle with no grant and no resend SHALL drive dout_leaf_interface2bft = 0.
REQ-029 resend=1 at cycle t SHALL drive the last sent packet (same addr) at t+1; with no packet sent since reset, drive 0; seq SHALL not advance.

Reset
REQ-030 reset SHALL clear FIFO pointers, all vld_interface2user, dout_leaf_interface2bft, seq counters, last-packet register, arbiter pointer (next search from port 0), and drop_count, effective next edge.
REQ-031 reset mid-transfer SHALL discard buffered and in-flight data; no packet emitted in the cycle after reset.

Configuration
REQ-032 With LEAF_DROP_CNT_EN defined, drop_count SHALL increment per dropped inbound packet, saturating at 16'hFFFF.
REQ-033 Without LEAF_DROP_CNT_EN, drop_count port and counter logic SHALL be absent; drop behaviour unchanged.

Verification
REQ-034 Inbound packet port=1, payload 0xDEADBEEF, ack=1 -> vld_interface2user[1]=1 next cycle, data 0xDEADBEEF, single transfer.
REQ-035 17 packets to port 0, ack=0, depth 16 -> 16 buffered, 17th dropped, drop_count=1; draining yields first 16 in order.
REQ-036 Both input ports vld continuously -> grants alternate 0,1,0,1; addr fields per port 0,1,2...; port 0 addr wraps 127->0 after 128 sends.
REQ-037 Send packet, then resend=1 with port 0 vld -> duplicate packet (same addr) emitted, ack_interface2user=0 that cycle, port 0 sent next cycle with addr+1.
REQ-038 Inbound packet port=5 (NUM_OUT_PORTS=2) -> no vld asserted, drop_count increments.
REQ-039 reset asserted with 3 words in FIFO 0 and grant active -> next cycle all vld=0, dout=0, drop_count=0.

Source files
------------

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge
//   Bridges a leaf of the packet network (BFT) to a set of user streams.
//   Inbound : packets from the network are sorted by their port field into
//             one show-ahead FIFO per output port. A packet is dropped when its
//             port does not exist or its FIFO is full. The leaf field is ignored.
//   Outbound: a round-robin arbiter picks one requesting user input port per
//             cycle. The granted word is wrapped into a packet with that port's
//             destination leaf/port and a per-port sequence number. The packet
//             is registered onto the network output one cycle later. `resend`
//             replays the last packet that was sent.
//   Packet layout (MSB..LSB): valid | leaf | port | addr | payload.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   din_leaf_bft2interface     inbound packet from the network
//   dout_leaf_interface2bft    registered outbound packet to the network
//   resend                     replay the last outbound packet
//   dout_leaf_interface2user   per-output-port payload (show-ahead)
//   vld_interface2user         per-output-port valid (FIFO non-empty)
//   ack_user2interface         per-output-port accept from the user
//   din_leaf_user2interface    per-input-port payload from the user
//   vld_user2interface         per-input-port request from the user
//   ack_interface2user         per-input-port one-hot grant (combinational)
//   drop_count                 saturating inbound drop counter; present only
//                              when LEAF_DROP_CNT_EN is defined
module leaf_stream_bridge #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_LEAF_BITS = 5,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned NUM_ADDR_BITS = 7,
  parameter int unsigned PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
  parameter int unsigned NUM_IN_PORTS  = 2,
  parameter int unsigned NUM_OUT_PORTS = 2,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [NUM_IN_PORTS*NUM_LEAF_BITS-1:0] DEST_LEAF_TABLE = '0,
  parameter logic [NUM_IN_PORTS*NUM_PORT_BITS-1:0] DEST_PORT_TABLE = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [PACKET_BITS-1:0]                din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  resend,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  output logic [NUM_OUT_PORTS-1:0]              vld_interface2user,
  input  logic [NUM_OUT_PORTS-1:0]              ack_user2interface,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_IN_PORTS-1:0]               vld_user2interface,
  output logic [NUM_IN_PORTS-1:0]               ack_interface2user
`ifdef LEAF_DROP_CNT_EN
  ,
  output logic [15:0]                           drop_count
`endif
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned IW       = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int unsigned ADDR_LSB = PAYLOAD_BITS;
  localparam int unsigned PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int unsigned LEAF_LSB = PORT_LSB + NUM_PORT_BITS;

  // ---------------------------------------------------------------- inbound
  logic                     in_vld;
  logic [NUM_PORT_BITS-1:0] in_port;
  logic [PAYLOAD_BITS-1:0]  in_pay;
  logic [NUM_OUT_PORTS-1:0] wr_en;
  logic [NUM_OUT_PORTS-1:0] rd_en;
  logic                     unused_in_fields;

  assign in_vld  = din_leaf_bft2interface[PACKET_BITS-1];
  assign in_port = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign in_pay  = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  // Leaf and sequence fields of inbound packets carry no meaning here.
  assign unused_in_fields = ^{din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS],
                              din_leaf_bft2interface[ADDR_LSB +: NUM_ADDR_BITS]};

  for (genvar p = 0; p < NUM_OUT_PORTS; p++) begin : g_fifo
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                    full;
    logic                    empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    // Full is taken from the registered pointers, so a read in the same cycle
    // does not make room for a write.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = ((wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH));
    assign wr_en[p] = in_vld && (in_port == NUM_PORT_BITS'(p)) && !full;
    assign rd_en[p] = !empty && ack_user2interface[p];
    assign wr_ptr_d = wr_en[p] ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = rd_en[p] ? rd_ptr_q + 1'b1 : rd_ptr_q;

    assign vld_interface2user[p] = !empty;
    assign dout_leaf_interface2user[p*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en[p]) mem_q[wr_ptr_q[AW-1:0]] <= in_pay;
    end
  end

`ifdef LEAF_DROP_CNT_EN
  logic        in_drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Any valid packet not written to a FIFO was dropped (bad port or full).
  assign in_drop    = in_vld && (wr_en == '0);
  assign drop_cnt_d = (in_drop && (drop_cnt_q != '1)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  assign drop_count = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end
`endif

  // --------------------------------------------------------------- outbound
  logic [IW-1:0]                         rr_q, rr_d;
  logic [IW-1:0]                         cand;
  logic [IW-1:0]                         gnt_idx;
  logic                                  gnt_found;
  logic                                  send;
  logic [NUM_IN_PORTS*NUM_ADDR_BITS-1:0] seq_q, seq_d;
  logic [PACKET_BITS-1:0]                last_q, last_d;
  logic [PACKET_BITS-1:0]                dout_q, dout_d;
  logic [NUM_LEAF_BITS-1:0]              sel_leaf;
  logic [NUM_PORT_BITS-1:0]              sel_port;
  logic [NUM_ADDR_BITS-1:0]              sel_seq;
  logic [PAYLOAD_BITS-1:0]               sel_data;

  // rr_q holds the first port to examine (last grant + 1).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_IN_PORTS; k++) begin
      cand = IW'((32'(rr_q) + k) % NUM_IN_PORTS);
      if (!gnt_found && vld_user2interface[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    send               = gnt_found && !resend && !reset;
    ack_interface2user = '0;
    if (send) ack_interface2user[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_leaf = DEST_LEAF_TABLE[32'(gnt_idx)*NUM_LEAF_BITS +: NUM_LEAF_BITS];
    sel_port = DEST_PORT_TABLE[32'(gnt_idx)*NUM_PORT_BITS +: NUM_PORT_BITS];
    sel_seq  = seq_q[32'(gnt_idx)*NUM_ADDR_BITS +: NUM_ADDR_BITS];
    sel_data = din_leaf_user2interface[32'(gnt_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
    seq_d    = seq_q;
    rr_d     = rr_q;
    last_d   = last_q;
    dout_d   = '0;
    if (resend) begin
      dout_d = last_q;
    end else if (send) begin
      dout_d = {1'b1, sel_leaf, sel_port, sel_seq, sel_data};
      last_d = dout_d;
      seq_d[32'(gnt_idx)*NUM_ADDR_BITS +: NUM_ADDR_BITS] = sel_seq + 1'b1;
      rr_d   = (32'(gnt_idx) == NUM_IN_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q   <= '0;
      seq_q  <= '0;
      last_q <= '0;
      dout_q <= '0;
    end else begin
      rr_q   <= rr_d;
      seq_q  <= seq_d;
      last_q <= last_d;
      dout_q <= dout_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Scoreboard bench for leaf_stream_bridge (2 in / 2 out ports, depth 16).
// The driver applies stimulus one cycle at a time and pushes the expected
// responses (tagged with the cycle they must appear in) into queues; the
// negedge monitor pops and compares.
module tb_leaf_stream_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        resend = 1'b0;
  logic [48:0] din_bft = '0;
  logic [48:0] dout_bft;
  logic [63:0] dout_user;
  logic [1:0]  vld_out;
  logic [1:0]  ack_uout = '0;
  logic [63:0] din_user = '0;
  logic [1:0]  vld_uin = '0;
  logic [1:0]  ack_in;
`ifdef LEAF_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  leaf_stream_bridge #(
    .PAYLOAD_BITS   (32),
    .NUM_LEAF_BITS  (5),
    .NUM_PORT_BITS  (4),
    .NUM_ADDR_BITS  (7),
    .NUM_IN_PORTS   (2),
    .NUM_OUT_PORTS  (2),
    .FIFO_DEPTH     (16),
    .DEST_LEAF_TABLE(10'b00011_10001),
    .DEST_PORT_TABLE(8'h96)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_bft2interface  (din_bft),
    .dout_leaf_interface2bft (dout_bft),
    .resend                  (resend),
    .dout_leaf_interface2user(dout_user),
    .vld_interface2user      (vld_out),
    .ack_user2interface      (ack_uout),
    .din_leaf_user2interface (din_user),
    .vld_user2interface      (vld_uin),
    .ack_interface2user      (ack_in)
`ifdef LEAF_DROP_CNT_EN
    ,
    .drop_count              (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] pay; int unsigned tag; } fent_t;
  typedef struct { logic [48:0] v;   int unsigned tag; } pent_t;
  typedef struct { logic [1:0]  v;   int unsigned tag; } aent_t;

  fent_t outq [2][$];
  pent_t dq [$];
  aent_t aq [$];

  // Reference model state
  logic [4:0]  leaf_of [2] = '{5'd17, 5'd3};
  logic [3:0]  port_of [2] = '{4'd6, 4'd9};
  logic [6:0]  seq [2] = '{7'd0, 7'd0};
  logic [48:0] last = '0;
  int unsigned rr = 0;
  bit          busy [2] = '{0, 0};
  logic [31:0] sdata [2] = '{32'd0, 32'd0};
  int          gnt_prev = -1;
  int unsigned exp_drop = 0;
  int unsigned exp_drop_nxt = 0;
  bit          pend_flush = 0;
  bit          mon_en = 0;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [48:0] mk(input int port, input logic [31:0] pay);
    logic [4:0] lf;
    logic [6:0] ad;
    lf = 5'($urandom);
    ad = 7'($urandom);
    return {1'b1, lf, 4'(port), ad, pay};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (aq.size() > 0 && aq[0].tag == cyc) begin
        chk("ack_interface2user", 64'(ack_in), 64'(aq[0].v));
        void'(aq.pop_front());
      end
      if (dq.size() > 0 && dq[0].tag == cyc) begin
        chk("dout_bft", 64'(dout_bft), 64'(dq[0].v));
        void'(dq.pop_front());
      end
      for (int p = 0; p < 2; p++) begin
        bit ev;
        ev = (outq[p].size() > 0) && (outq[p][0].tag <= cyc);
        chk($sformatf("vld_out%0d", p), 64'(vld_out[p]), 64'(ev));
        if (ev) begin
          chk($sformatf("user_data%0d", p), 64'(dout_user[p*32 +: 32]), 64'(outq[p][0].pay));
          if (ack_uout[p]) void'(outq[p].pop_front());
        end
      end
`ifdef LEAF_DROP_CNT_EN
      chk("drop_count", 64'(drop_count), 64'(exp_drop));
`endif
    end
  end

  // Driver + reference model: one call = one clock cycle.
  task automatic step(input logic [48:0] pkt, input logic [1:0] uack, input logic rs,
                      input logic rst, input logic [1:0] want);
    logic [1:0]  g_oh;
    logic [48:0] nxt;
    bit          found;
    int          g;
    int          p;
    exp_drop = exp_drop_nxt;
    if (pend_flush) begin
      outq[0].delete();
      outq[1].delete();
      pend_flush = 0;
    end
    if (gnt_prev >= 0) busy[gnt_prev] = 0;
    gnt_prev = -1;
    for (int i = 0; i < 2; i++) begin
      if (!busy[i] && want[i]) begin
        busy[i]  = 1;
        sdata[i] = $urandom;
      end
    end
    reset    = rst;
    resend   = rs;
    ack_uout = uack;
    din_bft  = rst ? 49'd0 : pkt;
    vld_uin  = {busy[1], busy[0]};
    din_user = {sdata[1], sdata[0]};

    g_oh = '0;
    nxt  = '0;
    if (rst) begin
      rr = 0; seq[0] = '0; seq[1] = '0; last = '0;
      exp_drop_nxt = 0;
      pend_flush = 1;
    end else begin
      if (rs) begin
        nxt = last;
      end else begin
        found = 0; g = 0;
        for (int o = 0; o < 2; o++) begin
          int i;
          i = (rr + o) % 2;
          if (!found && busy[i]) begin found = 1; g = i; end
        end
        if (found) begin
          g_oh = 2'b01 << g;
          nxt  = {1'b1, leaf_of[g], port_of[g], seq[g], sdata[g]};
          last = nxt;
          seq[g] = seq[g] + 7'd1;
          rr = (g + 1) % 2;
          gnt_prev = g;
        end
      end
      if (pkt[48]) begin
        p = int'(pkt[42:39]);
        if (p < 2 && outq[p].size() < 16) outq[p].push_back('{pkt[31:0], cyc + 1});
        else if (exp_drop_nxt < 65535) exp_drop_nxt++;
      end
    end
    aq.push_back('{g_oh, cyc});
    dq.push_back('{nxt, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
    dq.push_back('{49'd0, cyc});  // output must be idle right after reset

    // single inbound word to port 1, user accepting
    step(mk(1, 32'hDEADBEEF), 2'b11, 0, 0, 2'b00);
    repeat (3) step('0, 2'b11, 0, 0, 2'b00);

    // 17 words to port 0 with no acceptance, then drain
    for (int n = 0; n < 17; n++) step(mk(0, $urandom), 2'b00, 0, 0, 2'b00);
    step('0, 2'b00, 0, 0, 2'b00);
    repeat (20) step('0, 2'b11, 0, 0, 2'b00);

    // nonexistent port
    step(mk(5, $urandom), 2'b11, 0, 0, 2'b00);
    step('0, 2'b11, 0, 0, 2'b00);

    // both inputs requesting continuously: alternation and sequence wrap
    repeat (260) step('0, 2'b11, 0, 0, 2'b11);
    repeat (2) step('0, 2'b11, 0, 0, 2'b00);

    // resend while port 0 requests
    step('0, 2'b11, 0, 0, 2'b01);
    step('0, 2'b11, 1, 0, 2'b01);
    step('0, 2'b11, 0, 0, 2'b01);
    repeat (2) step('0, 2'b11, 0, 0, 2'b00);

    // reset with buffered words and an active grant
    repeat (3) step(mk(0, $urandom), 2'b00, 0, 0, 2'b11);
    step(mk(7, $urandom), 2'b00, 0, 0, 2'b11);
    step('0, 2'b00, 0, 1, 2'b11);
    step('0, 2'b11, 0, 0, 2'b11);
    repeat (3) step('0, 2'b11, 0, 0, 2'b00);

    // randomized traffic
    repeat (3000) begin
      logic [48:0] pk;
      pk = ($urandom_range(0, 2) != 0) ? mk($urandom_range(0, 5), $urandom) : 49'd0;
      step(pk, 2'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0),
           2'($urandom));
    end
    repeat (40) step('0, 2'b11, 0, 0, 2'b00);
    @(negedge clk);
    #1;
    chk("fifos_drained", 64'(outq[0].size() + outq[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
